// File: rtl/rx_symbol_slicer.sv
// rx_symbol_slicer: symbol-rate PAM-4 slicer with adaptive reference level and windowed MSE
module rx_symbol_slicer #(
  parameter int LOG2_WIN = 10,
  parameter logic [17:0] REF_INIT = 18'd32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        sym_en,
  input  logic [17:0] x_in,
  output logic [1:0]  sym_out,
  output logic        sym_valid,
  output logic [17:0] err,
  output logic [17:0] ref_level,
  output logic [17:0] mse,
  output logic        stats_valid
);
  localparam int AW = 18 + LOG2_WIN;
  localparam int QW = 36 + LOG2_WIN;
  logic signed [17:0] x_s;
  logic v0, v2;
  logic [17:0] a, a1, a2;
  logic neg, outer;
  logic [18:0] lvl_d, lvl_o, lvl;
  logic signed [19:0] lvl_s, e_w;
  logic signed [17:0] e_sat;
  logic signed [35:0] sq;
  logic [35:0] q;
  logic [AW-1:0] acc_a, sum_a;
  logic [QW-1:0] acc_q, sum_q;
  logic [LOG2_WIN-1:0] cnt;
  // magnitude, decision thresholds, saturated error, square and running sums
  always_comb begin
    neg   = x_s[17];
    a     = neg ? ((~|x_s[16:0]) ? 18'd131071 : 18'(-x_s)) : 18'(x_s);
    lvl_d = {1'b0, ref_level} >> 1;
    lvl_o = {1'b0, ref_level} + lvl_d;
    outer = a >= ref_level;
    lvl   = outer ? lvl_o : lvl_d;
    lvl_s = neg ? -$signed({1'b0, lvl}) : $signed({1'b0, lvl});
    e_w   = $signed({{2{x_s[17]}}, x_s}) - lvl_s;
    e_sat = (e_w > 20'sd131071) ? 18'sd131071 : (e_w < -20'sd131072) ? -18'sd131072 : e_w[17:0];
    sq    = 36'($signed(err)) * 36'($signed(err));
    sum_a = acc_a + AW'(a2);
    sum_q = acc_q + QW'(q);
  end
  // capture the matched-filter sample on a qualified symbol strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      x_s <= '0;
      v0  <= 1'b0;
    end else begin
      v0 <= clk_en & sym_en;
      if (clk_en & sym_en) x_s <= x_in;
    end
  end
  // register decision and error; carry magnitude forward for averaging
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_out   <= '0;
      err       <= '0;
      sym_valid <= 1'b0;
      a1        <= '0;
    end else begin
      sym_valid <= v0;
      if (v0) begin
        sym_out <= {~neg, outer ^ neg};
        err     <= e_sat;
        a1      <= a;
      end
    end
  end
  // square the registered error
  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= '0;
      a2 <= '0;
      v2 <= 1'b0;
    end else begin
      v2 <= sym_valid;
      if (sym_valid) begin
        q  <= 36'(sq);
        a2 <= a1;
      end
    end
  end
  // accumulate over the window and publish reference level and MSE at its close
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_a       <= '0;
      acc_q       <= '0;
      cnt         <= '0;
      ref_level   <= REF_INIT;
      mse         <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= v2 && (cnt == '1);
      if (v2) begin
        if (cnt == '1) begin
          ref_level <= 18'(sum_a >> LOG2_WIN);
          mse       <= 18'(sum_q >> (LOG2_WIN + 18));
          acc_a     <= '0;
          acc_q     <= '0;
          cnt       <= '0;
        end else begin
          acc_a <= sum_a;
          acc_q <= sum_q;
          cnt   <= cnt + LOG2_WIN'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_rx_symbol_slicer.sv
// tb_rx_symbol_slicer: directed and random checks of rx_symbol_slicer against an arithmetic model
module tb_rx_symbol_slicer;
  localparam int L = 4;
  localparam int WIN = 16;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0, sym_en = 1'b0;
  logic [17:0] x_in = '0;
  logic [1:0] sym_out;
  logic sym_valid, stats_valid;
  logic [17:0] err, ref_level, mse;
  int total = 0, bad = 0;
  int m_r, m_mse, m_n, last_sym, last_err;
  longint m_sa, m_sq;

  rx_symbol_slicer #(.LOG2_WIN(L), .REF_INIT(18'd32768)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .sym_en(sym_en), .x_in(x_in),
    .sym_out(sym_out), .sym_valid(sym_valid), .err(err), .ref_level(ref_level),
    .mse(mse), .stats_valid(stats_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_r = 32768; m_mse = 0; m_n = 0; m_sa = 0; m_sq = 0;
  endfunction

  function automatic void model_sym(input int x, output int s, output int e, output bit cl);
    int a, lv;
    bit o;
    a  = (x < 0) ? -x : x;
    if (a > 131071) a = 131071;
    o  = a >= m_r;
    lv = o ? m_r + m_r / 2 : m_r / 2;
    if (x >= 0) s = o ? 3 : 2;
    else begin s = o ? 0 : 1; lv = -lv; end
    e = x - lv;
    if (e > 131071) e = 131071;
    if (e < -131072) e = -131072;
    m_sa += a;
    m_sq += longint'(e) * longint'(e);
    m_n++;
    cl = (m_n == WIN);
    if (cl) begin
      m_r   = int'(m_sa / WIN);
      m_mse = int'(((m_sq / WIN) >> 18) & 64'h3ffff);
      m_sa = 0; m_sq = 0; m_n = 0;
    end
  endfunction

  task automatic noise();
    int k;
    k = $urandom_range(0, 2);
    clk_en = (k == 2);
    sym_en = (k == 1);
    x_in = 18'($urandom);
  endtask

  task automatic quiet();
    clk_en = 1'b0; sym_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sym_out"}, int'(sym_out), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_sym_valid"}, int'(sym_valid), 0);
    chk({tag, "_ref"}, int'(ref_level), 32768);
    chk({tag, "_mse"}, int'(mse), 0);
    chk({tag, "_stats_valid"}, int'(stats_valid), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; quiet();
    repeat (n) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_outputs("rst");
  endtask

  task automatic send(input int x);
    int s, e;
    bit cl;
    model_sym(x, s, e, cl);
    @(negedge clk);
    clk_en = 1'b1; sym_en = 1'b1; x_in = 18'(x);
    @(negedge clk); noise();
    chk("sym_valid_e0", int'(sym_valid), 0);
    @(negedge clk); noise();
    chk("sym_valid_e1", int'(sym_valid), 1);
    chk("sym_out", int'(sym_out), s);
    chk("err", int'($signed(err)), e);
    last_sym = int'(sym_out);
    last_err = int'($signed(err));
    @(negedge clk); noise();
    chk("sym_valid_e2", int'(sym_valid), 0);
    chk("stats_valid_e2", int'(stats_valid), 0);
    @(negedge clk); noise();
    chk("stats_valid_e3", int'(stats_valid), int'(cl));
    chk("ref_level", int'(ref_level), m_r);
    chk("mse", int'(mse), m_mse);
  endtask

  function automatic int rand_x();
    logic [17:0] r;
    int k, x;
    if ($urandom_range(0, 7) == 0) begin
      r = 18'($urandom);
      return int'($signed(r));
    end
    k = int'($urandom_range(0, 3));
    x = (2 * k - 3) * (m_r / 2) + int'($urandom_range(0, m_r / 2)) - m_r / 4;
    if (x > 131071) x = 131071;
    if (x < -131072) x = -131072;
    return x;
  endfunction

  initial begin
    int thr_x[6] = '{0, -1, 32767, 32768, -32768, -32769};
    int thr_s[6] = '{2, 1, 2, 3, 0, 0};
    int thr_e[6] = '{-16384, 16383, 16383, -16384, 16384, 16383};
    int ideal[4] = '{49152, 16384, -16384, -49152};
    model_reset();
    do_reset(3);
    repeat (20) begin
      @(negedge clk);
      clk_en = 1'b1; sym_en = 1'b0; x_in = 18'($urandom);
      @(negedge clk);
      clk_en = 1'b0; sym_en = 1'($urandom_range(0, 1));
      chk("gate_sym_valid", int'(sym_valid), 0);
      chk("gate_stats_valid", int'(stats_valid), 0);
      repeat (2) @(negedge clk);
    end
    quiet();
    check_reset_outputs("gate");
    for (int i = 0; i < 6; i++) begin
      send(thr_x[i]);
      chk("thr_sym", last_sym, thr_s[i]);
      chk("thr_err", last_err, thr_e[i]);
    end
    send(-131072);
    chk("sat_neg_sym", last_sym, 0);
    chk("sat_neg_err", last_err, -81920);
    send(131071);
    chk("sat_pos_sym", last_sym, 3);
    chk("sat_pos_err", last_err, 81919);
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      send(ideal[i % 4]);
      chk("ideal_err", last_err, 0);
    end
    chk("ideal_ref", int'(ref_level), 32768);
    chk("ideal_mse", int'(mse), 0);
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      send(20480);
      chk("ofs_sym", last_sym, 2);
      chk("ofs_err", last_err, 4096);
    end
    chk("ofs_ref", int'(ref_level), 20480);
    chk("ofs_mse", int'(mse), 64);
    send(20480);
    chk("ofs_next_sym", last_sym, 3);
    chk("ofs_next_err", last_err, -10240);
    do_reset(1);
    for (int i = 0; i < 9; i++) send(rand_x());
    @(negedge clk);
    clk_en = 1'b1; sym_en = 1'b1; x_in = 18'(rand_x());
    @(negedge clk);
    quiet(); reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (4) begin
      chk("midrst_sym_valid", int'(sym_valid), 0);
      chk("midrst_stats_valid", int'(stats_valid), 0);
      @(negedge clk);
    end
    check_reset_outputs("midrst");
    for (int i = 0; i < 16; i++) send(16384);
    chk("midrst_ref", int'(ref_level), 16384);
    do_reset(1);
    for (int i = 0; i < 200; i++) send(rand_x());
    quiet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
